imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl_if.sv | 28 ++
 rtl/imem_fetch_ctrl.sv | 97 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch sequencer bus: instruction ROM port, redirect input and the IF/ID valid/ready handshake.
// master = the fetch controller, slave = the core/ROM side.
interface imem_fetch_ctrl_if #(
    parameter int QDEPTH = 2
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic          fetch_en;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic [CW-1:0] q_count;

    modport master (
        input  fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_pc, out_instr, q_count
    );

    modport slave (
        output fetch_en, imem_rdata, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_pc, out_instr, q_count
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures {pc, word} into a circular fetch queue
// and presents the head to IF/ID through registered outputs; redirects flush the queue.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    imem_fetch_ctrl_if.master  bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   mem_pc    [QDEPTH];
    logic [31:0]   mem_instr [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          out_valid_q;
    logic [31:0]   out_pc_q;
    logic [31:0]   out_instr_q;

    logic          deq;
    logic          enq;
    logic [PW-1:0] head_nxt;
    logic [CW-1:0] count_nxt;
    logic [31:0]   nxt_pc;
    logic [31:0]   nxt_instr;

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_instr = out_instr_q;
    assign bus.q_count   = count;

    // Output registers are loaded from the head the queue will have after this edge; when that
    // head is the slot being written now, the word comes straight from the ROM port.
    always_comb begin
        deq       = out_valid_q & bus.out_ready;
        enq       = bus.fetch_en & ~bus.redirect_valid & ((count < CW'(QDEPTH)) | deq);
        head_nxt  = deq ? head + PW'(1) : head;
        count_nxt = count;
        if (enq && !deq) begin
            count_nxt = count + CW'(1);
        end else if (deq && !enq) begin
            count_nxt = count - CW'(1);
        end
        if (bus.redirect_valid) begin
            head_nxt  = '0;
            count_nxt = '0;
        end
        if (enq && (head_nxt == tail)) begin
            nxt_pc    = fetch_pc;
            nxt_instr = bus.imem_rdata;
        end else begin
            nxt_pc    = mem_pc[head_nxt];
            nxt_instr = mem_instr[head_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            head  <= head_nxt;
            count <= count_nxt;
            if (bus.redirect_valid) begin
                tail     <= '0;
                fetch_pc <= bus.redirect_pc & ~32'h3;
            end else if (enq) begin
                tail     <= tail + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            out_valid_q <= (count_nxt != '0);
            if (count_nxt != '0) begin
                out_pc_q    <= nxt_pc;
                out_instr_q <= nxt_instr;
            end
        end
    end

    // Queue storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc[tail]    <= fetch_pc;
            mem_instr[tail] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against a queue-based behavioural model.
module tb_imem_fetch_ctrl;
    localparam int QDEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0050_0113;
            32'h0000_0004: rom = 32'h00C0_0193;
            32'h0000_0040: rom = 32'h0080_01EF;
            32'h0000_0020: rom = 32'h0000_0000;
            default:       rom = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    imem_fetch_ctrl_if #(.QDEPTH(QDEPTH)) bus ();
    imem_fetch_ctrl_if #(.QDEPTH(QDEPTH)) wbus ();

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(QDEPTH)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (wbus)
    );

    assign bus.imem_rdata      = rom(bus.imem_addr);
    assign wbus.imem_rdata     = rom(wbus.imem_addr);
    assign wbus.fetch_en       = 1'b1;
    assign wbus.redirect_valid = 1'b0;
    assign wbus.redirect_pc    = 32'h0;
    assign wbus.out_ready      = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fe, input logic rv,
                                 input logic [31:0] rp, input logic ordy);
        reset              = rst;
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.out_ready      = ordy;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Reference: the queue head is what IF/ID sees after each edge; pop, then flush or push.
    entry_t      mq[$];
    entry_t      ment;
    logic [31:0] mpc;
    logic        mvalid;
    logic [31:0] mout_pc;
    logic [31:0] mout_instr;
    bit          model_ready = 1'b0;
    bit          mdeq;
    bit          menq;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mpc         = 32'h0;
            mvalid      = 1'b0;
            mout_pc     = 32'h0;
            mout_instr  = 32'h0;
            model_ready = 1'b1;
        end else if (model_ready) begin
            mdeq = mvalid && bus.out_ready;
            menq = bus.fetch_en && !bus.redirect_valid && ((mq.size() < QDEPTH) || mdeq);
            if (mdeq) void'(mq.pop_front());
            if (bus.redirect_valid) begin
                mq.delete();
                mpc = {bus.redirect_pc[31:2], 2'b00};
            end else if (menq) begin
                ment.pc    = mpc;
                ment.instr = rom(mpc);
                mq.push_back(ment);
                mpc = mpc + 32'd4;
            end
            if (mq.size() > 0) begin
                mvalid     = 1'b1;
                mout_pc    = mq[0].pc;
                mout_instr = mq[0].instr;
            end else begin
                mvalid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("model_out_valid", 32'(bus.out_valid), 32'(mvalid));
            checkOutput("model_out_pc", bus.out_pc, mout_pc);
            checkOutput("model_out_instr", bus.out_instr, mout_instr);
            checkOutput("model_q_count", 32'(bus.q_count), 32'(mq.size()));
            checkOutput("model_imem_addr", bus.imem_addr, mpc);
        end
    end

    initial begin
        logic [31:0] rp;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        waitCycle();
        waitCycle();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rst_q_count", 32'(bus.q_count), 32'h0);
        checkOutput("rst_out_pc", bus.out_pc, 32'h0);
        checkOutput("rst_out_instr", bus.out_instr, 32'h0);
        checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
        checkOutput("wrap_rst_addr", wbus.imem_addr, 32'hFFFF_FFFC);

        // Streaming from reset, plus the wrapping instance
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        waitCycle();
        checkOutput("t1_valid0", 32'(bus.out_valid), 32'h1);
        checkOutput("t1_pc0", bus.out_pc, 32'h0);
        checkOutput("t1_instr0", bus.out_instr, 32'h0050_0113);
        checkOutput("wrap_pc0", wbus.out_pc, 32'hFFFF_FFFC);
        waitCycle();
        checkOutput("t1_pc1", bus.out_pc, 32'h4);
        checkOutput("t1_instr1", bus.out_instr, 32'h00C0_0193);
        checkOutput("wrap_pc1", wbus.out_pc, 32'h0);
        checkOutput("wrap_instr1", wbus.out_instr, 32'h0050_0113);
        waitCycle();
        checkOutput("t1_pc2", bus.out_pc, 32'h8);
        checkOutput("wrap_pc2", wbus.out_pc, 32'h4);

        // Backpressure saturates the queue, then release drains without gaps
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) waitCycle();
        checkOutput("t2_q_full", 32'(bus.q_count), 32'h2);
        checkOutput("t2_pc_hold", bus.imem_addr, 32'h8);
        checkOutput("t2_head", bus.out_pc, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        waitCycle();
        checkOutput("t2_rel_pc1", bus.out_pc, 32'h4);
        waitCycle();
        checkOutput("t2_rel_pc2", bus.out_pc, 32'h8);

        // Redirect flushes a full queue
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        waitCycle();
        checkOutput("t3_q_full", 32'(bus.q_count), 32'h2);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        waitCycle();
        checkOutput("t3_q_flushed", 32'(bus.q_count), 32'h0);
        checkOutput("t3_valid_low", 32'(bus.out_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        waitCycle();
        checkOutput("t3_tgt_pc", bus.out_pc, 32'h40);
        checkOutput("t3_tgt_instr", bus.out_instr, 32'h0080_01EF);

        // Redirect with unaligned target while the head 0x10 is accepted
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        waitCycle();
        checkOutput("t4_head", bus.out_pc, 32'h10);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h43, 1'b1);
        waitCycle();
        checkOutput("t4_addr_aligned", bus.imem_addr, 32'h40);
        checkOutput("t4_valid_low", 32'(bus.out_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        waitCycle();
        checkOutput("t4_next_pc", bus.out_pc, 32'h40);

        // Reset wins over a simultaneous redirect on a full queue
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) waitCycle();
        checkOutput("t6_q_full", 32'(bus.q_count), 32'h2);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
        waitCycle();
        checkOutput("t6_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("t6_q_count", 32'(bus.q_count), 32'h0);
        checkOutput("t6_addr", bus.imem_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                rp = 32'($urandom_range(0, 255));
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0,
                          rp,
                          $urandom_range(0, 4) < 3);
            waitCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
